// File: rtl/seq_detector.sv
// seq_detector: serial pattern detector with a runtime-programmable pattern.
// Accepted bits shift into a history register. When the last len bits match
// the programmed pattern, a registered one-cycle match pulse is produced and
// a saturating counter is incremented. Matches may overlap or be
// non-overlapping, and the current detector phase is exposed on state.
module seq_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cnt_clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [1:0]         state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_ARMED  = 2'd2;
  localparam logic [1:0] ST_UNUSED = 2'd3;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_d;
  logic [CNT_W-1:0]   count_d;
  logic [1:0]         state_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               hit;

  // Mask that selects the low len bits of the history for comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // Candidate history and fill if the current bit is accepted, and whether that bit completes the pattern.
  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    fill_inc   = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
    hit        = (len_q != '0) && (fill_inc >= len_q) &&
                 (((hist_shift ^ pattern_q) & len_mask) == '0);
  end

  // Next configuration, history, fill and match. A configuration load takes priority over any bit presented in the same cycle.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    if (cfg_we) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      len_d     = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d  = hist_shift;
      match_d = hit;
      fill_d  = (hit && !overlap_q) ? '0 : fill_inc;
    end
  end

  // Detector phase follows directly from the next length and fill. The unused encoding falls back to IDLE.
  always_comb begin
    if (state == ST_UNUSED) begin
      state_d = ST_IDLE;
    end else if (len_d == '0) begin
      state_d = ST_IDLE;
    end else if (fill_d < len_d) begin
      state_d = ST_HUNT;
    end else begin
      state_d = ST_ARMED;
    end
  end

  // Saturating match counter. A clear on the same edge as a match wins.
  always_comb begin
    count_d = match_count;
    if (cnt_clear) begin
      count_d = '0;
    end else if (match_d && (match_count != CNT_MAX)) begin
      count_d = match_count + 1'b1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q   <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b0;
      hist_q      <= '0;
      fill_q      <= '0;
      match       <= 1'b0;
      match_count <= '0;
      state       <= ST_IDLE;
    end else begin
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      overlap_q   <= overlap_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match       <= match_d;
      match_count <= count_d;
      state       <= state_d;
    end
  end

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: directed stimulus with a queue-based reference model of
// the detector. A compare process checks the model against the DUT on every
// falling edge. Hand-computed literal checks pin both the model and the DUT.
module tb_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk;
  logic               reset;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;
  logic               cnt_clear;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [1:0]         state;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .cnt_clear(cnt_clear), .match(match),
    .match_count(match_count), .state(state)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model. Keeps the bits received since the last restart and
  // compares the newest len of them against the pattern.
  bit               q[$];
  logic [MAX_LEN-1:0] m_pat = '0;
  int               m_len = 0;
  bit               m_ov = 0;
  int               exp_match = 0;
  int               exp_count = 0;
  int               exp_state = 0;

  initial begin
    bit hit;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        m_pat = '0; m_len = 0; m_ov = 0;
        exp_match = 0; exp_count = 0;
      end else begin
        exp_match = 0;
        if (cfg_we) begin
          m_pat = cfg_pattern;
          m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
          m_ov  = cfg_overlap;
          q.delete();
        end else if (in_valid) begin
          q.push_back(in_bit);
          if (q.size() > MAX_LEN) void'(q.pop_front());
          hit = 0;
          if (m_len != 0 && q.size() >= m_len) begin
            hit = 1;
            for (int k = 0; k < m_len; k++)
              if (q[q.size()-1-k] != m_pat[k]) hit = 0;
          end
          exp_match = hit;
          if (hit && !m_ov) q.delete();
        end
        if (cnt_clear) exp_count = 0;
        else if (exp_match != 0 && exp_count < (1 << CNT_W) - 1) exp_count++;
      end
      exp_state = (m_len == 0) ? 0 : (q.size() < m_len) ? 1 : 2;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_match", {31'd0, match}, exp_match);
      checkOutput("model_count", {28'd0, match_count}, exp_count);
      checkOutput("model_state", {30'd0, state}, exp_state);
    end
  end

  task automatic applyStimulus(input logic we, input logic [MAX_LEN-1:0] pat,
                               input logic [LEN_W-1:0] len, input logic ov,
                               input logic v, input logic b, input logic clr);
    cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    in_valid = v; in_bit = b; cnt_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ov);
    applyStimulus(1'b1, pat, len, ov, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    logic [4:0] s1_bits  = 5'b10101;
    logic [4:0] s1_match = 5'b00101;
    logic [4:0] s2_match = 5'b00100;
    logic [7:0] pa5      = 8'hA5;
    int         s1_state[5] = '{1, 1, 2, 2, 2};
    int         s2_state[5] = '{1, 1, 1, 1, 1};

    reset = 1'b1; cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    in_valid = 0; in_bit = 0; cnt_clear = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_match", {31'd0, match}, 0);
    checkOutput("reset_count", {28'd0, match_count}, 0);
    checkOutput("reset_state", {30'd0, state}, 0);

    // Overlapping detection of 101 on 1,0,1,0,1.
    configure(8'b101, 4'd3, 1'b1);
    checkOutput("ov_cfg_state", {30'd0, state}, 1);
    for (int i = 0; i < 5; i++) begin
      sendBit(s1_bits[4-i]);
      checkOutput("ov_match", {31'd0, match}, {31'd0, s1_match[4-i]});
      checkOutput("ov_state", {30'd0, state}, s1_state[i]);
    end
    checkOutput("ov_count", {28'd0, match_count}, 2);
    checkOutput("ov_model_count", exp_count, 2);
    idleCycle();
    checkOutput("ov_gap_match", {31'd0, match}, 0);

    // Non-overlapping detection of the same stream.
    configure(8'b101, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sendBit(s1_bits[4-i]);
      checkOutput("nov_match", {31'd0, match}, {31'd0, s2_match[4-i]});
      checkOutput("nov_state", {30'd0, state}, s2_state[i]);
    end
    checkOutput("nov_count", {28'd0, match_count}, 3);

    // Gapped input on pattern 11.
    configure(8'b11, 4'd2, 1'b0);
    sendBit(1'b1);
    checkOutput("gap_first", {31'd0, match}, 0);
    repeat (3) begin
      idleCycle();
      checkOutput("gap_idle_match", {31'd0, match}, 0);
      checkOutput("gap_idle_state", {30'd0, state}, 1);
    end
    sendBit(1'b1);
    checkOutput("gap_match", {31'd0, match}, 1);
    idleCycle();
    checkOutput("gap_pulse_end", {31'd0, match}, 0);
    checkOutput("gap_count", {28'd0, match_count}, 4);

    // Oversized length clamps to the full history width.
    configure(8'hA5, 4'd15, 1'b1);
    for (int i = 0; i < 8; i++) begin
      sendBit(pa5[7-i]);
      checkOutput("full_match", {31'd0, match}, (i == 7) ? 1 : 0);
      checkOutput("full_state", {30'd0, state}, (i == 7) ? 2 : 1);
    end
    checkOutput("full_count", {28'd0, match_count}, 5);

    // Saturation and clear priority.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_count", {28'd0, match_count}, 0);
    configure(8'b1, 4'd1, 1'b1);
    repeat (20) sendBit(1'b1);
    checkOutput("sat_count", {28'd0, match_count}, 15);
    checkOutput("sat_model_count", exp_count, 15);
    checkOutput("sat_match", {31'd0, match}, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("clrwin_match", {31'd0, match}, 1);
    checkOutput("clrwin_count", {28'd0, match_count}, 0);

    // Configuration beats a simultaneous bit, then length 0 disables.
    applyStimulus(1'b1, 8'b1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("prec_match", {31'd0, match}, 0);
    checkOutput("prec_state", {30'd0, state}, 1);
    checkOutput("prec_count", {28'd0, match_count}, 0);
    configure(8'b1, 4'd0, 1'b1);
    checkOutput("dis_state", {30'd0, state}, 0);
    for (int i = 0; i < 4; i++) begin
      sendBit(i != 2);
      checkOutput("dis_match", {31'd0, match}, 0);
      checkOutput("dis_state_run", {30'd0, state}, 0);
    end

    // Asynchronous reset while a match is being pulsed.
    configure(8'b101, 4'd3, 1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    checkOutput("pre_rst_state", {30'd0, state}, 1);
    sendBit(1'b1);
    checkOutput("pre_rst_match", {31'd0, match}, 1);
    checkOutput("pre_rst_count", {28'd0, match_count}, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_match", {31'd0, match}, 0);
    checkOutput("rst_count", {28'd0, match_count}, 0);
    checkOutput("rst_state", {30'd0, state}, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    checkOutput("post_rst_match", {31'd0, match}, 0);
    checkOutput("post_rst_state", {30'd0, state}, 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
- Parametrised serial pattern detector; next generation of the two-input fixed-sequence FSM detector.
- Watches a qualified 1-bit stream and pulses `match` when the last `len` accepted bits equal a runtime-programmable pattern.
- Supports overlapping and non-overlapping detection, keeps a saturating match counter, and exposes detector state.
- Sits between a serial front end (deserialiser or protocol sniffer) and control logic that needs sync or marker events.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits; legal range 2..32.
- CNT_W, 16: width of the match counter.
- LEN_W, $clog2(MAX_LEN)+1: width of the length fields; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- cfg_we  input  1  load configuration this cycle.
- cfg_pattern  input  MAX_LEN  pattern; bit len-1 = first bit received, bit 0 = last bit received.
- cfg_len  input  LEN_W  pattern length; 0 = disabled.
- cfg_overlap  input  1  1 = overlapping matches allowed.
- in_valid  input  1  in_bit is accepted on this edge.
- in_bit  input  1  serial data bit.
- cnt_clear  input  1  synchronous clear of match_count.
- match  output  1  one-cycle pulse, registered.
- match_count  output  CNT_W  number of matches, saturating.
- state  output  2  0 = IDLE, 1 = HUNT, 2 = ARMED.

Behaviour:
- **Reset (async):**
  - Pattern, len, overlap, history, fill, match and match_count all go to 0; state goes to IDLE.
  - Deassertion is synchronous to clk, handled by the surrounding reset synchroniser.
- **Configuration:** on an edge with cfg_we=1:
  - Latch cfg_pattern, cfg_overlap and len.
  - len = cfg_len, clamped to MAX_LEN if larger.
  - Clear history and fill; match goes to 0.
  - match_count is untouched.
  - If in_valid is high in the same cycle, configuration wins and the bit is discarded.
- **History:** internal MAX_LEN-bit shift register; on an accepted bit, hist <= {hist[MAX_LEN-2:0], in_bit}.
- **Fill:** counts accepted bits since the last restart, saturating at MAX_LEN.
- **Match condition:** evaluated on the updated values: len != 0, fill_next >= len, and hist_next[len-1:0] == pattern[len-1:0] (compare only the low len bits; mask the upper bits).
- **Latency:** match is high in the cycle immediately after the edge that accepted the final pattern bit, for exactly one cycle.
  - match is 0 in any cycle following an edge with in_valid=0, and while cfg_we is applied.
- **Overlap mode:**
  - overlap=1: history and fill continue after a match, so pattern 11 on 1,1,1 matches after bits 2 and 3.
  - overlap=0: on a match edge, fill is forced to 0 (history may keep shifting), so the next match needs len fresh bits.
- **State machine (registered, derived from next values):**
  - IDLE when len == 0; no matches, but bits still shift.
  - HUNT when len != 0 and fill < len.
  - ARMED when len != 0 and fill >= len.
  - Transitions:
    - IDLE -> HUNT on cfg_we with a nonzero length.
    - HUNT -> ARMED when fill reaches len.
    - ARMED -> HUNT on a non-overlap match, or on cfg_we.
    - Any state -> IDLE on cfg_we with length 0.
  - State 3 is unused; if ever reached, it returns to IDLE at the next edge.
- **match_count:**
  - Increments on each edge that sets match.
  - Holds at 2^CNT_W-1 (saturates, no wrap).
  - cnt_clear=1 sets it to 0. If a match occurs on the same edge, clear wins and the count ends at 0; that match is still pulsed on `match`.
- **in_valid=0:** history, fill and state hold; match drops to 0.
- **len == MAX_LEN:** the full history is compared and fill saturates at MAX_LEN. Still legal.
- **len == 1:** every accepted bit equal to pattern[0] matches; with overlap=0, fill resets every match. Still legal.
- **Reset mid-stream:** all progress is lost and the configuration must be reloaded.

Test Plan:
- **Overlap, len 3:** load pattern 3'b101, len=3, overlap=1; stream 1,0,1,0,1 with in_valid continuous -> match pulses the cycle after bits 3 and 5; match_count=2; state HUNT, HUNT, ARMED, ARMED, ARMED.
- **Non-overlap, len 3:** same config with overlap=0, same stream -> single pulse after bit 3; match_count=1; state returns to HUNT after the match.
- **Gapped input, legacy sequence:** len=2, pattern 2'b11; stream 1,(in_valid=0 for 3 cycles),1 -> exactly one match pulse, one cycle after the second valid bit; no pulse during the gap.
- **Counter saturation and clear priority:**
  - With CNT_W=4 and pattern 1 (len 1, overlap 1), feed 20 ones -> match_count holds at 15.
  - Assert cnt_clear on a match edge -> count=0, match still pulses.
- **Config precedence:** assert cfg_we and in_valid in the same cycle -> bit ignored, fill=0, state HUNT; afterwards cfg_len=0 -> state IDLE and no match for any stream.
- **Async reset mid-pattern:** assert reset between edges after 2 of 3 pattern bits -> match, match_count and state read 0 immediately, without waiting for a clock edge.
